lzd_norm32: RTL

Multi-cycle 32-bit leading-zero counter and normalizer that time-shares a single `lzd8` instance across the four bytes of a captured word. It scans from the most significant byte down and stops at the first non-zero byte. It then registers the leading-zero count, the left-normalized word and a zero flag. It sits ahead of the mantissa-normalization step of the floating-point datapath and trades latency (1–4 scan cycles) for one LZD instead of four.

---
 rtl/lzd_norm32.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lzd_norm32.sv
// lzd_norm32: 32-bit leading-zero count and left normalize built around
// a single 8-bit LZD that is time-shared across the bytes, MSB first.

module lzd8 (
    input  logic [7:0] byteIn,
    output logic [3:0] lz
);

    always_comb begin
        lz = 4'd8;
        unique casez (byteIn)
            8'b1???????: lz = 4'd0;
            8'b01??????: lz = 4'd1;
            8'b001?????: lz = 4'd2;
            8'b0001????: lz = 4'd3;
            8'b00001???: lz = 4'd4;
            8'b000001??: lz = 4'd5;
            8'b0000001?: lz = 4'd6;
            8'b00000001: lz = 4'd7;
            8'b00000000: lz = 4'd8;
        endcase
    end

endmodule

module lzd_norm32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count,
    output logic [31:0] norm,
    output logic        zero
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [31:0] dataReg;
    logic [1:0]  idx;
    logic [5:0]  acc;

    logic [7:0]  sliceByte;
    logic [3:0]  lz;
    logic [5:0]  sum;
    logic        accept;
    logic        finish;
    logic [31:0] shifted;

    always_comb begin
        sliceByte = dataReg[31:24];
        unique case (idx)
            2'd3: sliceByte = dataReg[31:24];
            2'd2: sliceByte = dataReg[23:16];
            2'd1: sliceByte = dataReg[15:8];
            2'd0: sliceByte = dataReg[7:0];
        endcase
    end

    lzd8 uLzd (
        .byteIn (sliceByte),
        .lz     (lz)
    );

    assign sum    = acc + {2'b00, lz};
    assign accept = (state == IDLE) && start;
    assign finish = (state == SCAN) &&
                    ((lz != 4'd8) || (idx == 2'd0));

    // sum tops out at 32, so bit 5 alone marks the all-zero case
    assign shifted = sum[5] ? 32'd0 : (dataReg << sum[4:0]);

    assign busy = (state == SCAN);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (start)  stateNext = SCAN;
            SCAN: if (finish) stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataReg <= 32'd0;
            idx     <= 2'd0;
            acc     <= 6'd0;
        end else if (accept) begin
            dataReg <= din;
            idx     <= 2'd3;
            acc     <= 6'd0;
        end else if ((state == SCAN) && !finish) begin
            acc     <= acc + 6'd8;
            idx     <= idx - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done  <= 1'b0;
            count <= 6'd0;
            norm  <= 32'd0;
            zero  <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                count <= sum;
                norm  <= shifted;
                zero  <= sum[5];
            end
        end
    end

endmodule
